// File: rtl/popcount_pattern_gen_if.sv
// Output stream interface for popcount_pattern_gen.
//   vec_out   : current vector (WIDTH bits)
//   vec_valid : vec_out is valid
//   vec_ready : downstream accepts the current vector
//   vec_last  : final vector of the run, qualified by vec_valid
// master = generator side, slave = consumer side.
interface popcount_pattern_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] vec_out;
  logic             vec_valid;
  logic             vec_ready;
  logic             vec_last;

  modport master (
    output vec_out,
    output vec_valid,
    output vec_last,
    input  vec_ready
  );

  modport slave (
    input  vec_out,
    input  vec_valid,
    input  vec_last,
    output vec_ready
  );
endinterface

// File: rtl/popcount_pattern_gen.sv
// Emits every WIDTH-bit vector with exactly k ones, in ascending order, one per handshake.
// Successive vectors come from the next-combination (Gosper) step.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin a run (sampled only when idle), count_in = k sampled with it
//   busy       : high while a run is being emitted
//   emit_count : vectors transferred in the current or most recent run
//   done       : one-cycle pulse after the final transfer
//   err        : one-cycle pulse when start is given with count_in > WIDTH
//   vec_if     : vector stream (vec_out/vec_valid/vec_last out, vec_ready in)
module popcount_pattern_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CW-1:0]                 count_in,
  output logic                          busy,
  output logic [31:0]                   emit_count,
  output logic                          done,
  output logic                          err,
  popcount_pattern_gen_if.master        vec_if
);

  localparam int unsigned XW = WIDTH + 1;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [CW-1:0]    k_q, k_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [XW-1:0]    v_x, c_x, r_x;
  int unsigned      ctz;
  logic             ctz_found;
  logic [WIDTH-1:0] next_vec, start_vec, last_vec;
  logic             transfer, is_last;

  // Gosper step, computed one bit wider so the carry out of v + c is not lost.
  always_comb begin
    v_x       = {1'b0, vec_q};
    c_x       = v_x & (~v_x + XW'(1));
    r_x       = v_x + c_x;
    ctz       = 0;
    ctz_found = 1'b0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (c_x[i] && !ctz_found) begin
        ctz       = i;
        ctz_found = 1'b1;
      end
    end
    next_vec  = WIDTH'((((r_x ^ v_x) >> 2) >> ctz) | r_x);
    start_vec = WIDTH'((XW'(1) << count_in) - XW'(1));
    // The run ends on the k ones packed into the MSBs.
    last_vec  = WIDTH'((XW'(1) << k_q) - XW'(1)) << (WIDTH - 32'(k_q));
  end

  assign transfer = (state_q == StEmit) && vec_if.vec_ready;
  assign is_last  = (state_q == StEmit) && (vec_q == last_vec);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count_in > CW'(WIDTH)) begin
            err_d = 1'b1;
          end else begin
            state_d = StEmit;
            vec_d   = start_vec;
            k_d     = count_in;
            cnt_d   = '0;
          end
        end
      end
      StEmit: begin
        // start is deliberately ignored here
        if (transfer) begin
          cnt_d = cnt_q + 32'd1;
          if (is_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            vec_d = next_vec;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign vec_if.vec_out   = vec_q;
  assign vec_if.vec_valid = (state_q == StEmit);
  assign vec_if.vec_last  = is_last;
  assign busy             = (state_q == StEmit);
  assign emit_count       = cnt_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_popcount_pattern_gen.sv
module tb_popcount_pattern_gen;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] count_in;
  logic          busy, done, err;
  logic [31:0]   emit_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];

  popcount_pattern_gen_if #(.WIDTH(WIDTH)) vif ();

  popcount_pattern_gen #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count_in  (count_in),
    .busy      (busy),
    .emit_count(emit_count),
    .done      (done),
    .err       (err),
    .vec_if    (vif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: all WIDTH-bit values in ascending order whose popcount is k.
  task automatic build_expected(input int k);
    logic [WIDTH-1:0] t;
    exp_q.delete();
    for (int v = 0; v < (1 << WIDTH); v++) begin
      t = v[WIDTH-1:0];
      if ($countones(t) == k) exp_q.push_back(t);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vec"},   vif.vec_out,   0);
    check({tag, "_valid"}, vif.vec_valid, 0);
    check({tag, "_last"},  vif.vec_last,  0);
    check({tag, "_busy"},  busy,          0);
    check({tag, "_done"},  done,          0);
    check({tag, "_err"},   err,           0);
    check({tag, "_count"}, emit_count,    0);
  endtask

  task automatic run(input int k, input bit rand_ready, input int abort_after,
                     input bit mid_start);
    int               idx;
    int               budget;
    bit               stalled;
    logic [WIDTH-1:0] held_vec;
    logic             held_last;
    logic [31:0]      held_cnt;
    build_expected(k);
    count_in = CW'(k);
    start    = 1'b1;
    step();
    start = 1'b0;
    check("first_valid", vif.vec_valid, 1);
    check("busy_on",     busy,          1);
    check("count_start", emit_count,    0);
    idx     = 0;
    budget  = 4000;
    stalled = 1'b0;
    while (idx < exp_q.size() && budget > 0) begin
      budget--;
      if (stalled) begin
        check("stall_vec",   vif.vec_out,  held_vec);
        check("stall_last",  vif.vec_last, held_last);
        check("stall_count", emit_count,   held_cnt);
        stalled = 1'b0;
      end
      vif.vec_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_start && idx == 20) begin
        start    = 1'b1;
        count_in = CW'(2);
      end
      if (vif.vec_ready) begin
        check("vec",        vif.vec_out,             exp_q[idx]);
        check("last",       vif.vec_last,            idx == exp_q.size() - 1);
        check("popcount",   $countones(vif.vec_out), k);
        check("emit_count", emit_count,              idx);
        idx++;
      end else begin
        held_vec  = vif.vec_out;
        held_last = vif.vec_last;
        held_cnt  = emit_count;
        stalled   = 1'b1;
      end
      step();
      start = 1'b0;
      if (abort_after != 0 && idx == abort_after) return;
    end
    check("run_length",    idx,           exp_q.size());
    check("done_pulse",    done,          1);
    check("busy_off",      busy,          0);
    check("valid_off",     vif.vec_valid, 0);
    check("last_off",      vif.vec_last,  0);
    check("final_count",   emit_count,    exp_q.size());
    check("vec_hold_last", vif.vec_out,   exp_q[exp_q.size() - 1]);
    step();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    count_in      = '0;
    vif.vec_ready = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;

    run(2, 1'b0, 0, 1'b0);
    run(0, 1'b0, 0, 1'b0);
    run(8, 1'b0, 0, 1'b0);

    // Illegal k: error pulse only, no run, count from previous run kept.
    count_in = CW'(9);
    start    = 1'b1;
    step();
    start = 1'b0;
    check("err_pulse",   err,           1);
    check("err_valid",   vif.vec_valid, 0);
    check("err_busy",    busy,          0);
    check("err_count",   emit_count,    1);
    step();
    check("err_one_cycle", err,           0);
    check("err_idle",      vif.vec_valid, 0);

    run(4, 1'b1, 0, 1'b1);

    // Reset mid-run after the 10th transfer.
    run(3, 1'b0, 10, 1'b0);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    step();
    check("midrst_no_done", done,          0);
    check("midrst_idle",    vif.vec_valid, 0);

    run(1, 1'b0, 0, 1'b0);

    // Reset wins over a simultaneous start.
    rst      = 1'b1;
    start    = 1'b1;
    count_in = CW'(2);
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_vs_start_valid", vif.vec_valid, 0);
    check("rst_vs_start_busy",  busy,          0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/popcount_pattern_gen.md
Name: popcount_pattern_gen

Overview:
- Inverse of the bit-counting math functions: given a target population count k, emits every WIDTH-bit vector with exactly k ones, one per handshake.
- Vectors are emitted in ascending numeric order, using the next-combination (Gosper) step.
- Used as a stimulus source for popcount/countbits datapaths and for exhaustive k-of-N selection masks.
- Streams on a valid/ready output interface; runs are started with a one-cycle start request.

Parameters:
- WIDTH, 8, vector width in bits; legal range 2..16.
- CW, $clog2(WIDTH+1), width of the count_in field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new run; sampled only in IDLE.
- count_in  input  CW  target number of ones k; sampled with start.
- busy  output  1  high while in EMIT.
- vec_out  output  WIDTH  current vector.
- vec_valid  output  1  vec_out is valid.
- vec_ready  input  1  downstream accepts.
- vec_last  output  1  marks the final vector of the run; qualified by vec_valid.
- emit_count  output  32  number of vectors transferred in the current or most recent run, unsigned.
- done  output  1  one-cycle pulse after the final transfer.
- err  output  1  one-cycle pulse when start is given with count_in > WIDTH.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst has priority over all other inputs.
- Reset values:
  - state = IDLE.
  - vec_out = 0.
  - vec_valid = 0, vec_last = 0, busy = 0, done = 0, err = 0.
  - emit_count = 0.
- States: IDLE and EMIT.
- IDLE, start=1 with count_in <= WIDTH:
  - Next cycle: vec_out = (1<<k)-1, vec_valid = 1, busy = 1, emit_count = 0, state = EMIT.
  - vec_last = 1 in that same cycle if k==0 or k==WIDTH (single-vector runs).
  - Latency from start to first valid is exactly one cycle.
- IDLE, start=1 with count_in > WIDTH:
  - err = 1 for one cycle; state stays IDLE; vec_valid stays 0; emit_count is unchanged.
- IDLE, start=0: outputs hold; done and err are 0.
- start is ignored while in EMIT. No error is flagged for an ignored start.
- EMIT, transfer (vec_valid && vec_ready):
  - emit_count increments by 1.
  - If vec_last: next cycle vec_valid = 0, vec_last = 0, busy = 0, done = 1 (one cycle), state = IDLE. vec_out holds the last vector.
  - Otherwise vec_out takes the next value, computed from v:
    - c = v & -v
    - r = v + c
    - next = (((r ^ v) >> 2) >> ctz(c)) | r
    - All arithmetic is done at WIDTH+1 bits; the result is truncated to WIDTH bits.
- vec_last = 1 exactly when vec_out equals the k ones packed into the MSBs, i.e. ((1<<k)-1) << (WIDTH-k).
- Backpressure: while vec_valid && !vec_ready, vec_out, vec_last and emit_count hold stable.
- Throughput: one vector per cycle when vec_ready stays high.
- Every emitted vector has popcount exactly k. Vectors are strictly increasing and there are no duplicates.
- Run length is C(WIDTH,k).
- Final emit_count is C(WIDTH,k). For WIDTH=8: k=0→1, k=2→28, k=4→70, k=8→1.
- Reset mid-run: the next cycle is at reset values. The partial run is discarded and done is not pulsed.
- Simultaneous start and rst: rst wins.

Test Plan:
- start, k=2, vec_ready tied 1 → first valid one cycle after start; sequence begins 0x03, 0x05, 0x06, 0x09, 0x0A, 0x0C, 0x11; final vector 0xC0 with vec_last=1; emit_count=28; done pulses once the cycle after the last transfer. Bench checks $countbits(vec_out,1'b1)==2 on every transfer.
- Edge counts:
  - k=0 → single vector 0x00 with vec_last=1, emit_count=1.
  - k=8 → single vector 0xFF with vec_last=1, emit_count=1.
  - Both: busy drops and done pulses the cycle after the transfer.
- k=9 (illegal) → err=1 for exactly one cycle; vec_valid stays 0; busy stays 0; state remains IDLE; a following legal start works normally.
- k=4 with random vec_ready (about 50% duty) → vec_out stable on every stall cycle; 70 distinct strictly increasing vectors; last vector 0xF0; a start pulsed mid-run is ignored.
- k=3, assert rst after the 10th transfer → next cycle all outputs are at reset values; no done pulse; a new start with k=1 yields 0x01, 0x02, ... 0x80, emit_count=8.
